// File: rtl/ysyx_24080014_pkg.sv
// Shared definitions for the writeback stage and the load extraction logic.
// Holds the load funct3 encodings, the datapath width and the WBU state encoding.
package ysyx_24080014_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    COMMIT   = 2'd2
  } wbu_state_e;

endpackage

// File: rtl/ysyx_24080014_load_ext.sv
// Combinational load data extraction: selects byte/half/word from an aligned
// memory word, sign- or zero-extends it, and flags misaligned or illegal loads.
module ysyx_24080014_load_ext
  import ysyx_24080014_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  output logic [XLEN-1:0] data,
  output logic            misalign,
  output logic            illegal
);

  function automatic logic [XLEN-1:0] sext8(input logic signed [7:0] b);
    logic signed [XLEN-1:0] w;
    w = b;
    return w;
  endfunction

  function automatic logic [XLEN-1:0] sext16(input logic signed [15:0] h);
    logic signed [XLEN-1:0] w;
    w = h;
    return w;
  endfunction

  function automatic logic [XLEN-1:0] zext8(input logic [7:0] b);
    return {{(XLEN-8){1'b0}}, b};
  endfunction

  function automatic logic [XLEN-1:0] zext16(input logic [15:0] h);
    return {{(XLEN-16){1'b0}}, h};
  endfunction

  logic [XLEN-1:0] byte_shift;
  logic [XLEN-1:0] half_shift;
  logic [7:0]      byte_v;
  logic [15:0]     half_v;

  assign byte_shift = rdata >> {addr_lo, 3'b000};
  assign half_shift = rdata >> {addr_lo[1], 4'b0000};
  assign byte_v     = byte_shift[7:0];
  assign half_v     = half_shift[15:0];

  always_comb begin
    data     = '0;
    misalign = 1'b0;
    illegal  = 1'b0;
    unique case (funct3)
      F3_LB:  data = sext8(byte_v);
      F3_LBU: data = zext8(byte_v);
      F3_LH: begin
        data     = sext16(half_v);
        misalign = addr_lo[0];
      end
      F3_LHU: begin
        data     = zext16(half_v);
        misalign = addr_lo[0];
      end
      F3_LW: begin
        data     = rdata;
        misalign = (addr_lo != 2'b00);
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ysyx_24080014_wbu.sv
// Writeback unit: accepts one retiring instruction from the EXU, waits for load
// data when needed, and issues a single registered GPR write plus commit pulse.
module ysyx_24080014_wbu #(
  parameter int XLEN        = ysyx_24080014_pkg::XLEN,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            exu_valid,
  output logic            exu_ready,
  input  logic [XLEN-1:0] exu_pc,
  input  logic [4:0]      exu_rd,
  input  logic            exu_wen,
  input  logic [XLEN-1:0] exu_result,
  input  logic            exu_is_load,
  input  logic [2:0]      exu_funct3,
  input  logic [1:0]      exu_addr_lo,
  input  logic            lsu_rvalid,
  input  logic [XLEN-1:0] lsu_rdata,
  output logic            gpr_wen,
  output logic [4:0]      gpr_waddr,
  output logic [XLEN-1:0] gpr_wdata,
  output logic            commit_valid,
  output logic [XLEN-1:0] commit_pc,
  output logic            load_fault,
  output logic            spurious_rdata
);

  import ysyx_24080014_pkg::*;

  wbu_state_e      state;
  logic [XLEN-1:0] pc_p1;
  logic [4:0]      rd_p1;
  logic            wen_p1;
  logic [2:0]      funct3_p1;
  logic [1:0]      addr_lo_p1;
  logic            fault_p1;
  logic [15:0]     cnt_p1;
  logic [15:0]     cnt_nxt;

  logic [2:0]      ext_funct3;
  logic [1:0]      ext_addr_lo;
  logic [XLEN-1:0] ext_data;
  logic            ext_misalign;
  logic            ext_illegal;

  // In IDLE the extractor checks the incoming instruction so alignment and
  // funct3 faults are known at accept; afterwards it decodes the latched load.
  assign ext_funct3  = (state == IDLE) ? exu_funct3  : funct3_p1;
  assign ext_addr_lo = (state == IDLE) ? exu_addr_lo : addr_lo_p1;
  assign cnt_nxt     = cnt_p1 + 16'd1;
  assign exu_ready   = (state == IDLE);

  ysyx_24080014_load_ext u_load_ext (
    .rdata    (lsu_rdata),
    .funct3   (ext_funct3),
    .addr_lo  (ext_addr_lo),
    .data     (ext_data),
    .misalign (ext_misalign),
    .illegal  (ext_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      pc_p1          <= '0;
      rd_p1          <= '0;
      wen_p1         <= 1'b0;
      funct3_p1      <= '0;
      addr_lo_p1     <= '0;
      fault_p1       <= 1'b0;
      cnt_p1         <= '0;
      gpr_wen        <= 1'b0;
      gpr_waddr      <= '0;
      gpr_wdata      <= '0;
      commit_valid   <= 1'b0;
      commit_pc      <= '0;
      load_fault     <= 1'b0;
      spurious_rdata <= 1'b0;
    end else begin
      // Commit-side outputs are pulses: cleared unless this edge enters COMMIT.
      gpr_wen      <= 1'b0;
      gpr_waddr    <= '0;
      gpr_wdata    <= '0;
      commit_valid <= 1'b0;
      commit_pc    <= '0;
      load_fault   <= 1'b0;

      if (lsu_rvalid && (state != WAIT_MEM)) begin
        spurious_rdata <= 1'b1;
      end

      unique case (state)
        IDLE: begin
          if (exu_valid) begin
            pc_p1      <= exu_pc;
            rd_p1      <= exu_rd;
            wen_p1     <= exu_wen;
            funct3_p1  <= exu_funct3;
            addr_lo_p1 <= exu_addr_lo;
            cnt_p1     <= '0;
            if (exu_is_load) begin
              fault_p1 <= ext_misalign | ext_illegal;
              state    <= WAIT_MEM;
            end else begin
              fault_p1     <= 1'b0;
              state        <= COMMIT;
              commit_valid <= 1'b1;
              commit_pc    <= exu_pc;
              gpr_wen      <= exu_wen && (exu_rd != 5'd0);
              gpr_waddr    <= exu_rd;
              gpr_wdata    <= exu_result;
            end
          end
        end

        WAIT_MEM: begin
          cnt_p1 <= cnt_nxt;
          // A returning read beats a timeout that expires on the same edge.
          if (lsu_rvalid) begin
            state        <= COMMIT;
            commit_valid <= 1'b1;
            commit_pc    <= pc_p1;
            gpr_wen      <= wen_p1 && (rd_p1 != 5'd0) && !fault_p1;
            gpr_waddr    <= rd_p1;
            gpr_wdata    <= ext_data;
            load_fault   <= fault_p1;
          end else if (cnt_nxt == 16'(MEM_TIMEOUT)) begin
            state        <= COMMIT;
            fault_p1     <= 1'b1;
            commit_valid <= 1'b1;
            commit_pc    <= pc_p1;
            gpr_waddr    <= rd_p1;
            load_fault   <= 1'b1;
          end
        end

        COMMIT: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_24080014_wbu.sv
// Directed self-checking bench for the writeback unit, run with a short
// memory timeout so the timeout path is reached quickly.
module tb_ysyx_24080014_wbu;

  localparam int XLEN = 32;
  localparam int TMO  = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            exu_valid = 1'b0;
  logic            exu_ready;
  logic [XLEN-1:0] exu_pc = '0;
  logic [4:0]      exu_rd = '0;
  logic            exu_wen = 1'b0;
  logic [XLEN-1:0] exu_result = '0;
  logic            exu_is_load = 1'b0;
  logic [2:0]      exu_funct3 = '0;
  logic [1:0]      exu_addr_lo = '0;
  logic            lsu_rvalid = 1'b0;
  logic [XLEN-1:0] lsu_rdata = '0;
  logic            gpr_wen;
  logic [4:0]      gpr_waddr;
  logic [XLEN-1:0] gpr_wdata;
  logic            commit_valid;
  logic [XLEN-1:0] commit_pc;
  logic            load_fault;
  logic            spurious_rdata;

  int errors = 0;
  int checks = 0;

  ysyx_24080014_wbu #(.XLEN(XLEN), .MEM_TIMEOUT(TMO)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .exu_valid      (exu_valid),
    .exu_ready      (exu_ready),
    .exu_pc         (exu_pc),
    .exu_rd         (exu_rd),
    .exu_wen        (exu_wen),
    .exu_result     (exu_result),
    .exu_is_load    (exu_is_load),
    .exu_funct3     (exu_funct3),
    .exu_addr_lo    (exu_addr_lo),
    .lsu_rvalid     (lsu_rvalid),
    .lsu_rdata      (lsu_rdata),
    .gpr_wen        (gpr_wen),
    .gpr_waddr      (gpr_waddr),
    .gpr_wdata      (gpr_wdata),
    .commit_valid   (commit_valid),
    .commit_pc      (commit_pc),
    .load_fault     (load_fault),
    .spurious_rdata (spurious_rdata)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [31:0] pc, input logic [4:0] rd, input logic wen,
                        input logic [31:0] res, input logic ld, input logic [2:0] f3,
                        input logic [1:0] alo);
    @(negedge clk);
    exu_valid   = 1'b1;
    exu_pc      = pc;
    exu_rd      = rd;
    exu_wen     = wen;
    exu_result  = res;
    exu_is_load = ld;
    exu_funct3  = f3;
    exu_addr_lo = alo;
    @(posedge clk);
    #1;
    exu_valid = 1'b0;
  endtask

  task automatic pulse_rvalid(input logic [31:0] d);
    @(negedge clk);
    lsu_rvalid = 1'b1;
    lsu_rdata  = d;
    @(posedge clk);
    #1;
    lsu_rvalid = 1'b0;
    lsu_rdata  = '0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (exu_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", exu_ready); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++;
    if ({commit_valid, gpr_wen, load_fault, spurious_rdata} !== 4'b0000)
      begin errors++; $display("FAIL reset_flags: got %b want 0000", {commit_valid, gpr_wen, load_fault, spurious_rdata}); end
    checks++;
    if ({gpr_waddr, gpr_wdata, commit_pc} !== '0)
      begin errors++; $display("FAIL reset_data: got waddr=%h wdata=%h pc=%h want 0", gpr_waddr, gpr_wdata, commit_pc); end
    checks++;
    if (exu_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after: got %b want 1", exu_ready); end
  endtask

  task automatic test_alu();
    accept(32'h8000_0000, 5'd5, 1'b1, 32'h1234_ABCD, 1'b0, 3'b000, 2'b00);
    checks++;
    if ({commit_valid, gpr_wen, load_fault, exu_ready} !== 4'b1100)
      begin errors++; $display("FAIL alu_flags: got cv/wen/flt/rdy=%b want 1100", {commit_valid, gpr_wen, load_fault, exu_ready}); end
    checks++;
    if (gpr_waddr !== 5'd5 || gpr_wdata !== 32'h1234_ABCD || commit_pc !== 32'h8000_0000)
      begin errors++; $display("FAIL alu_data: got waddr=%0d wdata=%h pc=%h want 5 1234abcd 80000000", gpr_waddr, gpr_wdata, commit_pc); end
    step();
    checks++;
    if ({commit_valid, gpr_wen} !== 2'b00 || gpr_wdata !== '0 || commit_pc !== '0 || exu_ready !== 1'b1)
      begin errors++; $display("FAIL alu_one_cycle: got cv=%b wen=%b wdata=%h pc=%h rdy=%b want 0 0 0 0 1", commit_valid, gpr_wen, gpr_wdata, commit_pc, exu_ready); end
  endtask

  task automatic test_rd_zero();
    accept(32'h8000_0010, 5'd0, 1'b1, 32'hFFFF_FFFF, 1'b0, 3'b000, 2'b00);
    checks++;
    if ({commit_valid, gpr_wen} !== 2'b10)
      begin errors++; $display("FAIL rd_zero: got cv/wen=%b want 10", {commit_valid, gpr_wen}); end
    step();
  endtask

  task automatic test_load_ext();
    logic [2:0]  f3  [6] = '{3'b000, 3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    logic [1:0]  alo [6] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd0, 2'd0};
    logic [31:0] exp [6] = '{32'h0000_007F, 32'hFFFF_FFFF, 32'h0000_0080,
                             32'hFFFF_80FF, 32'h0000_7F01, 32'h80FF_7F01};
    for (int i = 0; i < 6; i++) begin
      accept(32'h8000_0100 + 32'(i * 4), 5'd10, 1'b1, 32'hDEAD_BEEF, 1'b1, f3[i], alo[i]);
      checks++;
      if (commit_valid !== 1'b0 || exu_ready !== 1'b0)
        begin errors++; $display("FAIL load%0d_wait: got cv=%b rdy=%b want 0 0", i, commit_valid, exu_ready); end
      repeat (i % 3) @(posedge clk);
      pulse_rvalid(32'h80FF_7F01);
      checks++;
      if ({commit_valid, gpr_wen, load_fault} !== 3'b110 || gpr_waddr !== 5'd10)
        begin errors++; $display("FAIL load%0d_commit: got cv/wen/flt=%b waddr=%0d want 110 10", i, {commit_valid, gpr_wen, load_fault}, gpr_waddr); end
      checks++;
      if (gpr_wdata !== exp[i] || commit_pc !== 32'h8000_0100 + 32'(i * 4))
        begin errors++; $display("FAIL load%0d_data: got wdata=%h pc=%h want %h", i, gpr_wdata, commit_pc, exp[i]); end
      step();
      checks++;
      if (commit_valid !== 1'b0 || gpr_wen !== 1'b0)
        begin errors++; $display("FAIL load%0d_pulse: got cv=%b wen=%b want 0 0", i, commit_valid, gpr_wen); end
    end
  endtask

  task automatic test_faults();
    logic [2:0] f3  [3] = '{3'b010, 3'b001, 3'b011};
    logic [1:0] alo [3] = '{2'd2, 2'd1, 2'd0};
    for (int i = 0; i < 3; i++) begin
      accept(32'h8000_0200 + 32'(i * 4), 5'd7, 1'b1, 32'h0, 1'b1, f3[i], alo[i]);
      repeat (2) @(posedge clk);
      checks++;
      if (commit_valid !== 1'b0)
        begin errors++; $display("FAIL fault%0d_drain: got cv=%b want 0", i, commit_valid); end
      pulse_rvalid(32'h1122_3344);
      checks++;
      if ({commit_valid, gpr_wen, load_fault} !== 3'b101 || commit_pc !== 32'h8000_0200 + 32'(i * 4))
        begin errors++; $display("FAIL fault%0d: got cv/wen/flt=%b pc=%h want 101", i, {commit_valid, gpr_wen, load_fault}, commit_pc); end
      step();
    end
  endtask

  task automatic test_rvalid_tie();
    accept(32'h8000_0300, 5'd3, 1'b1, 32'h0, 1'b1, 3'b010, 2'd0);
    repeat (TMO - 1) @(posedge clk);
    pulse_rvalid(32'hCAFE_F00D);
    checks++;
    if ({commit_valid, gpr_wen, load_fault} !== 3'b110 || gpr_wdata !== 32'hCAFE_F00D)
      begin errors++; $display("FAIL rvalid_tie: got cv/wen/flt=%b wdata=%h want 110 cafef00d", {commit_valid, gpr_wen, load_fault}, gpr_wdata); end
    step();
  endtask

  task automatic test_timeout();
    accept(32'h8000_0400, 5'd4, 1'b1, 32'h0, 1'b1, 3'b010, 2'd0);
    for (int k = 1; k < TMO; k++) begin
      step();
      checks++;
      if (commit_valid !== 1'b0)
        begin errors++; $display("FAIL timeout_early%0d: got cv=%b want 0", k, commit_valid); end
    end
    step();
    checks++;
    if ({commit_valid, gpr_wen, load_fault} !== 3'b101 || commit_pc !== 32'h8000_0400)
      begin errors++; $display("FAIL timeout_commit: got cv/wen/flt=%b pc=%h want 101 80000400", {commit_valid, gpr_wen, load_fault}, commit_pc); end
    step();
    checks++;
    if (spurious_rdata !== 1'b0)
      begin errors++; $display("FAIL spurious_pre: got %b want 0", spurious_rdata); end
    pulse_rvalid(32'h5555_AAAA);
    checks++;
    if (spurious_rdata !== 1'b1 || commit_valid !== 1'b0)
      begin errors++; $display("FAIL spurious_set: got sp=%b cv=%b want 1 0", spurious_rdata, commit_valid); end
    repeat (3) step();
    checks++;
    if (spurious_rdata !== 1'b1)
      begin errors++; $display("FAIL spurious_sticky: got %b want 1", spurious_rdata); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    exu_valid = 1'b1; exu_pc = 32'h8000_0500; exu_rd = 5'd1; exu_wen = 1'b1;
    exu_result = 32'h0000_00AA; exu_is_load = 1'b0;
    @(posedge clk); #1;
    exu_pc = 32'h8000_0504; exu_rd = 5'd2; exu_result = 32'h0000_00BB;
    checks++;
    if (commit_pc !== 32'h8000_0500 || exu_ready !== 1'b0)
      begin errors++; $display("FAIL b2b_first: got pc=%h rdy=%b want 80000500 0", commit_pc, exu_ready); end
    step();
    checks++;
    if (commit_valid !== 1'b0 || exu_ready !== 1'b1)
      begin errors++; $display("FAIL b2b_gap: got cv=%b rdy=%b want 0 1", commit_valid, exu_ready); end
    step();
    exu_valid = 1'b0;
    checks++;
    if (commit_valid !== 1'b1 || commit_pc !== 32'h8000_0504 || gpr_wdata !== 32'h0000_00BB || gpr_waddr !== 5'd2)
      begin errors++; $display("FAIL b2b_second: got cv=%b pc=%h wdata=%h waddr=%0d want 1 80000504 bb 2", commit_valid, commit_pc, gpr_wdata, gpr_waddr); end
    step();
  endtask

  task automatic test_reset_mid_load();
    accept(32'h8000_0600, 5'd9, 1'b1, 32'h0, 1'b1, 3'b010, 2'd0);
    step();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (exu_ready !== 1'b1 || {commit_valid, gpr_wen, load_fault, spurious_rdata} !== 4'b0000)
      begin errors++; $display("FAIL midreset_async: got rdy=%b flags=%b want 1 0000", exu_ready, {commit_valid, gpr_wen, load_fault, spurious_rdata}); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    pulse_rvalid(32'h0BAD_0BAD);
    checks++;
    if ({commit_valid, gpr_wen} !== 2'b00 || spurious_rdata !== 1'b1)
      begin errors++; $display("FAIL midreset_no_commit: got cv/wen=%b sp=%b want 00 1", {commit_valid, gpr_wen}, spurious_rdata); end
    step();
    checks++;
    if (commit_valid !== 1'b0 || exu_ready !== 1'b1)
      begin errors++; $display("FAIL midreset_idle: got cv=%b rdy=%b want 0 1", commit_valid, exu_ready); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_rd_zero();
    test_load_ext();
    test_faults();
    test_rvalid_tie();
    test_timeout();
    test_back_to_back();
    test_reset_mid_load();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got no completion want finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

endmodule
